// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a 16-bit subtract-and-compare GCD datapath.
// Loads operand A then operand B from the shared bus, then issues one
// subtraction per RUN cycle from the lt/gt/eq status until the registers
// match. An iteration watchdog aborts runs that can never converge.
module gcd_controller #(
    parameter int unsigned MAX_ITER = 65535,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ack,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             ldA,
    output logic             ldB,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE,
        LDA,
        LDB,
        RUN,
        DONE,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

    state_t state;
    state_t state_next;
    logic   at_limit;
    logic   step;

    assign at_limit = (iter == ITER_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Iteration counter: cleared when a run is accepted, bumped once per subtraction.
    // It cannot pass ITER_LIMIT because the watchdog suppresses any step at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter <= '0;
        end else if (state == IDLE && start) begin
            iter <= '0;
        end else if (step) begin
            iter <= iter + 1'b1;
        end
    end

    // Next-state logic; in RUN equality wins over the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LDA;
            LDA:  state_next = LDB;
            LDB:  state_next = RUN;
            RUN: begin
                if (eq) begin
                    state_next = DONE;
                end else if (at_limit) begin
                    state_next = ERR;
                end
            end
            DONE: if (ack) state_next = IDLE;
            ERR:  if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; RUN outputs depend on the live compare status.
    always_comb begin
        sel1   = 1'b0;
        sel2   = 1'b0;
        sel_in = 1'b0;
        ldA    = 1'b0;
        ldB    = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        busy   = (state != IDLE);
        step   = 1'b0;
        case (state)
            LDA: ldA = 1'b1;
            LDB: ldB = 1'b1;
            RUN: begin
                if (!eq && !at_limit) begin
                    if (gt) begin
                        sel1   = 1'b1;
                        sel_in = 1'b1;
                        ldA    = 1'b1;
                        step   = 1'b1;
                    end else if (lt) begin
                        sel2   = 1'b1;
                        sel_in = 1'b1;
                        ldB    = 1'b1;
                        step   = 1'b1;
                    end
                end
            end
            DONE: done = 1'b1;
            ERR:  err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: two instances (default watchdog and MAX_ITER=8),
// each driving a small behavioural datapath. Expected GCD, subtraction count,
// latency and watchdog outcome come from a Euclid-quotient reference model.
module tb_gcd_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start, ack, lt, gt, eq;
    logic [1:0] sel1, sel2, sel_in, ldA, ldB, done, err, busy;
    logic [15:0] iter_v [2];
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic [15:0] op_a [2];
    logic [15:0] op_b [2];
    logic [15:0] bus [2];
    logic [15:0] result [2];

    int checks = 0;
    int failures = 0;

    gcd_controller dut (
        .clk(clk), .rst(rst), .start(start[0]), .ack(ack[0]),
        .lt(lt[0]), .gt(gt[0]), .eq(eq[0]),
        .sel1(sel1[0]), .sel2(sel2[0]), .sel_in(sel_in[0]),
        .ldA(ldA[0]), .ldB(ldB[0]), .done(done[0]), .err(err[0]),
        .busy(busy[0]), .iter(iter_v[0])
    );

    gcd_controller #(.MAX_ITER(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(start[1]), .ack(ack[1]),
        .lt(lt[1]), .gt(gt[1]), .eq(eq[1]),
        .sel1(sel1[1]), .sel2(sel2[1]), .sel_in(sel_in[1]),
        .ldA(ldA[1]), .ldB(ldB[1]), .done(done[1]), .err(err[1]),
        .busy(busy[1]), .iter(iter_v[1])
    );

    // Datapath model: compare, subtractor, bus mux and gated result.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lt[i] = ra[i] < rb[i];
            gt[i] = ra[i] > rb[i];
            eq[i] = ra[i] == rb[i];
            bus[i] = sel_in[i] ? ((sel1[i] ? ra[i] : rb[i]) - (sel2[i] ? ra[i] : rb[i]))
                               : (ldA[i] ? op_a[i] : op_b[i]);
            result[i] = done[i] ? ra[i] : 16'd0;
        end
    end

    // Datapath registers.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ldA[i]) ra[i] <= bus[i];
            if (ldB[i]) rb[i] <= bus[i];
        end
    end

    // Reference: gcd via Euclid, subtraction count = sum of quotients - 1.
    function automatic void ref_model(input int unsigned a, input int unsigned b,
                                      input int unsigned maxi, output int unsigned g,
                                      output int unsigned k, output bit e);
        int unsigned x, y, r, qs;
        if (a == b) begin
            g = a; k = 0; e = 1'b0;
        end else if (a == 0 || b == 0) begin
            g = 0; k = maxi; e = 1'b1;
        end else begin
            x = a; y = b; qs = 0;
            while (y != 0) begin
                qs += x / y;
                r = x % y;
                x = y;
                y = r;
            end
            g = x;
            k = qs - 1;
            e = (k > maxi);
            if (e) begin
                g = 0;
                k = maxi;
            end
        end
    endfunction

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input string name);
        int unsigned g, k, maxi, exp_lat;
        bit e;
        int cyc, pulses;
        maxi = (d == 0) ? 65535 : 8;
        ref_model(a, b, maxi, g, k, e);
        exp_lat = 4 + k;
        @(negedge clk);
        op_a[d] = a; op_b[d] = b; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        cyc = 1; pulses = 0;
        checks++;
        if ({ldA[d], ldB[d], sel_in[d], busy[d]} !== 4'b1001) begin
            failures++;
            $display("FAIL %s lda_phase: got ldA/ldB/sel_in/busy=%b want 1001", name,
                     {ldA[d], ldB[d], sel_in[d], busy[d]});
        end
        while (!(done[d] || err[d]) && cyc < 70000) begin
            if ((ldA[d] || ldB[d]) && sel_in[d]) pulses++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({done[d], err[d]} !== (e ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL %s outcome: got done/err=%b want %b", name, {done[d], err[d]},
                     e ? 2'b01 : 2'b10);
        end
        checks++;
        if (cyc != int'(exp_lat)) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        checks++;
        if (result[d] !== g[15:0]) begin
            failures++;
            $display("FAIL %s result: got %0d want %0d", name, result[d], g);
        end
        checks++;
        if (iter_v[d] !== k[15:0] || pulses != int'(k)) begin
            failures++;
            $display("FAIL %s iter: got iter=%0d pulses=%0d want %0d", name, iter_v[d], pulses, k);
        end
        checks++;
        if (busy[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_end: got %b want 1", name, busy[d]);
        end
        ack[d] = 1'b1;
        @(negedge clk);
        ack[d] = 1'b0;
        checks++;
        if ({busy[d], done[d], err[d]} !== 3'b000 || iter_v[d] !== k[15:0]) begin
            failures++;
            $display("FAIL %s ack_idle: got busy/done/err=%b iter=%0d want 000 iter=%0d", name,
                     {busy[d], done[d], err[d]}, iter_v[d], k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = '0; ack = '0;
        op_a[0] = '0; op_b[0] = '0; op_a[1] = '0; op_b[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], err[d], ldA[d], ldB[d], sel1[d], sel2[d], sel_in[d]} !== 8'd0
                || iter_v[d] !== 16'd0) begin
                failures++;
                $display("FAIL reset%0d: got outs=%b iter=%0d want 0", d,
                         {busy[d], done[d], err[d], ldA[d], ldB[d], sel1[d], sel2[d], sel_in[d]},
                         iter_v[d]);
            end
        end
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL ack_in_idle: got busy=%b want 0", busy[0]);
        end
    endtask

    task automatic test_directed();
        run_op(0, 16'd12, 16'd8, "gcd_12_8");
        run_op(0, 16'd7, 16'd7, "gcd_7_7");
        run_op(0, 16'd0, 16'd0, "gcd_0_0");
        run_op(1, 16'd5, 16'd0, "wd_5_0");
        checks++;
        if (ra[1] !== 16'd5) begin
            failures++;
            $display("FAIL wd_a_hold: got A=%0d want 5", ra[1]);
        end
        run_op(1, 16'd9, 16'd1, "wd_edge_9_1");
        run_op(1, 16'd10, 16'd1, "wd_over_10_1");
        run_op(0, 16'd65535, 16'd1, "gcd_65535_1");
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom_range(300, 1));
            b = 16'($urandom_range(300, 1));
            run_op(0, a, b, "rand_dflt");
            a = 16'($urandom_range(20, 0));
            b = 16'($urandom_range(20, 1));
            run_op(1, a, b, "rand_wd8");
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        op_a[0] = 16'd100; op_b[0] = 16'd3; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || iter_v[0] == 16'd0) begin
            failures++;
            $display("FAIL midrun_pre: got busy=%b iter=%0d want busy=1 iter>0", busy[0], iter_v[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy[0], done[0], err[0], ldA[0], ldB[0], sel1[0], sel2[0], sel_in[0]} !== 8'd0
            || iter_v[0] !== 16'd0) begin
            failures++;
            $display("FAIL midrun_reset: got outs=%b iter=%0d want 0",
                     {busy[0], done[0], err[0], ldA[0], ldB[0], sel1[0], sel2[0], sel_in[0]},
                     iter_v[0]);
        end
        run_op(0, 16'd9, 16'd6, "after_reset_9_6");
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        op_a[0] = 16'd12; op_b[0] = 16'd8; start[0] = 1'b1;
        cyc = 0;
        while (!done[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: got done=%b want 1 (timeout)", done[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({done[0], busy[0], ldA[0], ldB[0]} !== 4'b1100) begin
                failures++;
                $display("FAIL b2b_hold: got done/busy/ldA/ldB=%b want 1100",
                         {done[0], busy[0], ldA[0], ldB[0]});
            end
        end
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        checks++;
        if ({busy[0], done[0], ldA[0]} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle: got busy/done/ldA=%b want 000", {busy[0], done[0], ldA[0]});
        end
        @(negedge clk);
        start[0] = 1'b0;
        checks++;
        if ({ldA[0], busy[0]} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_restart: got ldA/busy=%b want 11", {ldA[0], busy[0]});
        end
        cyc = 0;
        while (!done[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done[0] !== 1'b1 || result[0] !== 16'd4 || iter_v[0] !== 16'd2) begin
            failures++;
            $display("FAIL b2b_rerun: got done=%b result=%0d iter=%0d want 1 4 2",
                     done[0], result[0], iter_v[0]);
        end
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
